tetris_game_sequencer: RTL
==========================

Name: tetris_game_sequencer

Overview:
- Frame-level scheduler for the Tetris datapath.
- On every vsync frame it sequences, in a fixed order: player input, gravity, piece lock, line clear, spawn and game-over detection.
- It drives the game-logic, line-clear and shape-spawn blocks through request/acknowledge handshakes, and owns key auto-repeat, the gravity timer and level progression.

Parameters:
GRAV_INIT  48  gravity period in frames at level 0
GRAV_MIN  4  minimum gravity period in frames
GRAV_STEP  4  period reduction per level
REPEAT_DELAY  10  frames from first press to first auto-repeat
REPEAT_RATE  3  frames between later auto-repeats
LINES_PER_LEVEL  10  cleared lines per level increment

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vsync  in  1  frame-sync level, synchronous to clk
keycode  in  8  HID keycode: 0x04 left, 0x07 right, 0x1A rotate, 0x16 soft drop, others ignored
move_req  out  1  move request to game logic, held until move_ack
move_dir  out  2  0 left, 1 right, 2 rotate, 3 down; stable while move_req=1
move_ack  in  1  1-cycle pulse, move completed
move_blocked  in  1  valid with move_ack; 1 = move rejected by collision
lock_req  out  1  write active piece into the board, held until lock_done
lock_done  in  1  1-cycle pulse
clear_start  out  1  1-cycle pulse, start the line-clear scan
clear_done  in  1  1-cycle pulse
lines_cleared  in  3  valid with clear_done, range 0..4
spawn_req  out  1  request new piece (newgen), held until spawn_ack
spawn_ack  in  1  1-cycle pulse
spawn_blocked  in  1  valid with spawn_ack; 1 = spawn position occupied
game_over  out  1  sticky game-over flag
level  out  4  current level, saturates at 15
lines_total  out  16  total cleared lines, saturating

Behaviour:
- Reset: all outputs are 0. Internal state: FSM=IDLE; grav_cnt=0; repeat_cnt=0; key_prev=0; lines_in_level=0.
- Reset mid-handshake: all request outputs are low on the first cycle after the reset edge. No ack is awaited afterwards.
- Frame tick: a 1-cycle internal pulse when vsync is 1 and vsync_d (vsync registered one cycle) is 0.
- Ticks arriving outside WAIT_FRAME are dropped. The frame is skipped and no counter advances.

FSM states:
- IDLE: go to SPAWN on the first tick.
- SPAWN: assert spawn_req. On spawn_ack, go to OVER if spawn_blocked, else WAIT_FRAME (grav_cnt=0).
- WAIT_FRAME: on tick, evaluate keys and go to INPUT.
- INPUT: if an action is pending, assert move_req with its move_dir and go to GRAVITY on move_ack. move_blocked is ignored here. If no action is pending, go to GRAVITY in the same cycle.
- GRAVITY:
  - Effective period P = 1 if keycode==0x16, else max(GRAV_INIT − GRAV_STEP*level, GRAV_MIN).
  - If grav_cnt+1 ≥ P: set grav_cnt=0 and request down (dir 3).
    - On ack with move_blocked=1, go to LOCK.
    - Otherwise go to WAIT_FRAME.
  - Else: grav_cnt++ and go to WAIT_FRAME.
- LOCK: assert lock_req. On lock_done, go to CLEAR.
- CLEAR: pulse clear_start on the entry cycle, then wait for clear_done.
  - lines_total += lines_cleared, saturating at 0xFFFF.
  - lines_in_level += lines_cleared. If the result is ≥ LINES_PER_LEVEL, subtract LINES_PER_LEVEL and increment level (saturating at 15).
  - Go to SPAWN.
- OVER: game_over=1 and no further requests are issued. Only reset leaves this state.

Key evaluation (once per tick, in WAIT_FRAME):
- New press: keycode ≠ key_prev and keycode is left, right or rotate.
  - Action is pending now.
  - repeat_cnt=REPEAT_DELAY−1.
- Held: keycode == key_prev and keycode is left or right.
  - If repeat_cnt==0: action is pending and repeat_cnt=REPEAT_RATE−1.
  - Else: repeat_cnt--.
- Rotate never repeats. Soft drop and unrecognised codes (including 0) produce no INPUT action.
- key_prev ← keycode on every tick.

Handshake rules:
- A req rises only in its owning state and falls on the cycle after its ack.
- Acks received while no request is outstanding are ignored.
- An ack on the same cycle as the req rise is accepted.
- At most one request is outstanding at any time.

Test Plan:
- Reset, then vsync ticks with spawn_ack (not blocked) after 2 cycles → spawn_req for exactly the cycles until ack; state reaches WAIT_FRAME; every output except spawn_req is 0.
- keycode=0x07 held for 15 frames, move acks unblocked → right moves on frames 1, 11 and 14 (in frame order); move_dir=1 each time.
- keycode=0x1A held for 12 frames → exactly one rotate (dir 2), no repeat.
- No key, level 0, down never blocked → a down request every 48th frame. Then keycode=0x16 → a down request every frame.
- Down acked with move_blocked=1 → lock_req until lock_done, then a 1-cycle clear_start. clear_done with lines_cleared=4, three times → lines_total=12, level=1, next gravity period 44.
- spawn_ack with spawn_blocked=1 → game_over=1 and stays 1; later ticks and keys cause no req. Reset asserted while lock_req=1 → lock_req=0 the next cycle and all outputs are cleared.

Source files
------------

// File: rtl/tetris_game_sequencer.sv
// Frame-level scheduler for the Tetris datapath: input, gravity, lock, line clear,
// spawn and game-over, driving the datapath blocks through req/ack handshakes.
module tetris_game_sequencer #(
  parameter int unsigned GRAV_INIT       = 48,
  parameter int unsigned GRAV_MIN        = 4,
  parameter int unsigned GRAV_STEP       = 4,
  parameter int unsigned REPEAT_DELAY    = 10,
  parameter int unsigned REPEAT_RATE     = 3,
  parameter int unsigned LINES_PER_LEVEL = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic [7:0]  keycode,
  output logic        move_req,
  output logic [1:0]  move_dir,
  input  logic        move_ack,
  input  logic        move_blocked,
  output logic        lock_req,
  input  logic        lock_done,
  output logic        clear_start,
  input  logic        clear_done,
  input  logic [2:0]  lines_cleared,
  output logic        spawn_req,
  input  logic        spawn_ack,
  input  logic        spawn_blocked,
  output logic        game_over,
  output logic [3:0]  level,
  output logic [15:0] lines_total
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SPAWN,
    S_WAIT_FRAME,
    S_INPUT,
    S_GRAVITY,
    S_GRAV_MOVE,
    S_LOCK,
    S_CLEAR,
    S_OVER
  } state_t;

  localparam logic [7:0]  KEY_LEFT   = 8'h04;
  localparam logic [7:0]  KEY_RIGHT  = 8'h07;
  localparam logic [7:0]  KEY_ROTATE = 8'h1A;
  localparam logic [7:0]  KEY_DROP   = 8'h16;

  localparam logic [1:0]  DIR_LEFT   = 2'd0;
  localparam logic [1:0]  DIR_RIGHT  = 2'd1;
  localparam logic [1:0]  DIR_ROTATE = 2'd2;
  localparam logic [1:0]  DIR_DOWN   = 2'd3;

  localparam logic [15:0] LP_GRAV_INIT  = 16'(GRAV_INIT);
  localparam logic [15:0] LP_GRAV_MIN   = 16'(GRAV_MIN);
  localparam logic [15:0] LP_GRAV_STEP  = 16'(GRAV_STEP);
  localparam logic [7:0]  LP_REP_DELAY  = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0]  LP_REP_RATE   = 8'(REPEAT_RATE - 1);
  localparam logic [7:0]  LP_LINES_LVL  = 8'(LINES_PER_LEVEL);

  state_t      r_state;
  logic        r_vsync_d;
  logic [15:0] r_grav_cnt;
  logic [7:0]  r_repeat_cnt;
  logic [7:0]  r_key_prev;
  logic [7:0]  r_lines_in_level;
  logic        r_move_req;
  logic [1:0]  r_move_dir;
  logic        r_lock_req;
  logic        r_clear_start;
  logic        r_spawn_req;
  logic        r_game_over;
  logic [3:0]  r_level;
  logic [15:0] r_lines_total;

  logic        w_tick;
  logic        w_is_lr;
  logic        w_is_rot;
  logic        w_new_press;
  logic        w_held;
  logic        w_repeat_fire;
  logic        w_key_pending;
  logic [1:0]  w_key_dir;
  logic [15:0] w_grav_reduce;
  logic [15:0] w_grav_floor;
  logic [15:0] w_period;
  logic        w_grav_due;
  logic [16:0] w_lines_sum;
  logic [7:0]  w_lvl_sum;

  assign w_tick = vsync & ~r_vsync_d;

  // Key classification: only left/right auto-repeat; rotate fires on a new press only.
  assign w_is_lr       = (keycode == KEY_LEFT) || (keycode == KEY_RIGHT);
  assign w_is_rot      = (keycode == KEY_ROTATE);
  assign w_new_press   = (keycode != r_key_prev) && (w_is_lr || w_is_rot);
  assign w_held        = (keycode == r_key_prev) && w_is_lr;
  assign w_repeat_fire = w_held && (r_repeat_cnt == '0);
  assign w_key_pending = w_new_press || w_repeat_fire;

  always_comb begin
    w_key_dir = DIR_ROTATE;
    if (keycode == KEY_LEFT)       w_key_dir = DIR_LEFT;
    else if (keycode == KEY_RIGHT) w_key_dir = DIR_RIGHT;
  end

  // Gravity period floors at GRAV_MIN; the comparison avoids unsigned wrap at high levels.
  assign w_grav_reduce = LP_GRAV_STEP * {12'd0, r_level};
  assign w_grav_floor  = w_grav_reduce + LP_GRAV_MIN;

  always_comb begin
    w_period = LP_GRAV_MIN;
    if (keycode == KEY_DROP)              w_period = 16'd1;
    else if (LP_GRAV_INIT >= w_grav_floor) w_period = LP_GRAV_INIT - w_grav_reduce;
  end

  assign w_grav_due  = (r_grav_cnt + 16'd1) >= w_period;
  assign w_lines_sum = {1'b0, r_lines_total} + {14'd0, lines_cleared};
  assign w_lvl_sum   = r_lines_in_level + {5'd0, lines_cleared};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_vsync_d        <= 1'b0;
      r_grav_cnt       <= '0;
      r_repeat_cnt     <= '0;
      r_key_prev       <= '0;
      r_lines_in_level <= '0;
      r_move_req       <= 1'b0;
      r_move_dir       <= '0;
      r_lock_req       <= 1'b0;
      r_clear_start    <= 1'b0;
      r_spawn_req      <= 1'b0;
      r_game_over      <= 1'b0;
      r_level          <= '0;
      r_lines_total    <= '0;
    end else begin
      r_vsync_d     <= vsync;
      r_clear_start <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state     <= S_SPAWN;
            r_spawn_req <= 1'b1;
          end
        end

        S_SPAWN: begin
          if (spawn_ack) begin
            r_spawn_req <= 1'b0;
            if (spawn_blocked) begin
              r_state     <= S_OVER;
              r_game_over <= 1'b1;
            end else begin
              r_state    <= S_WAIT_FRAME;
              r_grav_cnt <= '0;
            end
          end
        end

        S_WAIT_FRAME: begin
          if (w_tick) begin
            r_key_prev <= keycode;
            if (w_new_press)        r_repeat_cnt <= LP_REP_DELAY;
            else if (w_repeat_fire) r_repeat_cnt <= LP_REP_RATE;
            else if (w_held)        r_repeat_cnt <= r_repeat_cnt - 8'd1;

            // With nothing to move, INPUT is bypassed straight to gravity evaluation.
            if (w_key_pending) begin
              r_state    <= S_INPUT;
              r_move_req <= 1'b1;
              r_move_dir <= w_key_dir;
            end else begin
              r_state <= S_GRAVITY;
            end
          end
        end

        S_INPUT: begin
          if (move_ack) begin
            r_move_req <= 1'b0;
            r_state    <= S_GRAVITY;
          end
        end

        S_GRAVITY: begin
          if (w_grav_due) begin
            r_grav_cnt <= '0;
            r_move_req <= 1'b1;
            r_move_dir <= DIR_DOWN;
            r_state    <= S_GRAV_MOVE;
          end else begin
            r_grav_cnt <= r_grav_cnt + 16'd1;
            r_state    <= S_WAIT_FRAME;
          end
        end

        S_GRAV_MOVE: begin
          if (move_ack) begin
            r_move_req <= 1'b0;
            if (move_blocked) begin
              r_state    <= S_LOCK;
              r_lock_req <= 1'b1;
            end else begin
              r_state <= S_WAIT_FRAME;
            end
          end
        end

        S_LOCK: begin
          if (lock_done) begin
            r_lock_req    <= 1'b0;
            r_clear_start <= 1'b1;
            r_state       <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          if (clear_done) begin
            r_lines_total <= w_lines_sum[16] ? '1 : w_lines_sum[15:0];
            if (w_lvl_sum >= LP_LINES_LVL) begin
              r_lines_in_level <= w_lvl_sum - LP_LINES_LVL;
              if (r_level != 4'hF) r_level <= r_level + 4'd1;
            end else begin
              r_lines_in_level <= w_lvl_sum;
            end
            r_state     <= S_SPAWN;
            r_spawn_req <= 1'b1;
          end
        end

        S_OVER: begin
          r_state <= S_OVER;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign move_req    = r_move_req;
  assign move_dir    = r_move_dir;
  assign lock_req    = r_lock_req;
  assign clear_start = r_clear_start;
  assign spawn_req   = r_spawn_req;
  assign game_over   = r_game_over;
  assign level       = r_level;
  assign lines_total = r_lines_total;

endmodule
